addsub_rr_scheduler: RTL and testbench

//   Time-shares one universal_adder_subtractor between NREQ requesters.

---
 rtl/addsub_sched_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/universal_adder_subtractor.sv | 30 +++
 rtl/addsub_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_addsub_rr_scheduler.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_sched_pkg
// Description : Shared types and constants for the add/subtract scheduler.
//               - state_t : scheduler FSM states (IDLE, EXEC, RESP)
//               - OP_ADD / OP_SUB : operation mode encodings
//               - signed_ovf() : two's-complement overflow from sign bits
// Revision    : 1.0  initial release
// ============================================================================
package addsub_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Overflow of A + B' where B' is B inverted for subtract: both effective
    // operands share a sign and the result sign differs from it.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic r_msb,
                                        input logic m);
        logic b_eff;
        b_eff = b_msb ^ (m == OP_SUB);
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

endpackage : addsub_sched_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Selects the first asserted
//               request at or after ptr, wrapping around NREQ.
// Ports       : req   in  NREQ          request vector
//               ptr   in  $clog2(NREQ)  highest-priority position
//               grant out NREQ          one-hot grant (zero if no request)
//               idx   out $clog2(NREQ)  index of the granted request
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import addsub_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] w_rot;
    logic [IW-1:0]   w_off;
    logic            w_found;
    logic [IW:0]     w_sum;

    // Rotate so that bit 0 is the position ptr points at; the first set bit
    // then gives the offset from ptr to the winner.
    assign w_rot = NREQ'({req, req} >> ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = IW'(k);
            end
        end
    end

    // ptr + offset, reduced mod NREQ (NREQ need not be a power of two).
    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign idx   = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
    assign grant = w_found ? (NREQ'(1) << idx) : '0;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/universal_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : universal_adder_subtractor
// Description : WIDTH-bit adder/subtractor. M=0 adds, M=1 computes A + ~B + 1.
//               Cout is the carry out of the MSB (for subtract, 1 = no borrow).
// Ports       : A, B   in  WIDTH  operands
//               M      in  1      mode (0 add, 1 subtract)
//               Result out WIDTH  sum/difference mod 2^WIDTH
//               Cout   out 1      carry out
// Revision    : 1.0  initial release
// ============================================================================
module universal_adder_subtractor
    import addsub_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic [WIDTH-1:0] Result,
    output logic             Cout
);

    logic [WIDTH-1:0] w_b_eff;

    assign w_b_eff = B ^ {WIDTH{M == OP_SUB}};
    assign {Cout, Result} = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, M};

endmodule : universal_adder_subtractor
`default_nettype wire

// File: rtl/addsub_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : addsub_rr_scheduler
// Description : Time-shares one universal_adder_subtractor between NREQ
//               requesters with round-robin arbitration. Operands are captured
//               at grant, computed in EXEC and the registered result is held in
//               RESP until the consumer accepts it.
// Ports       : clk, rst_n (synchronous, active-low)
//               req_valid/req_ready  NREQ        request handshake (ready one-hot)
//               req_a/req_b          NREQ*WIDTH  packed operands
//               req_m                NREQ        0 add, 1 subtract
//               rsp_valid/rsp_ready  1           response handshake
//               rsp_result           WIDTH       result mod 2^WIDTH
//               rsp_cout             1           carry out (subtract: 1 = no borrow)
//               rsp_id               $clog2(NREQ) owner of the result
//               rsp_ovf              1           signed overflow (ADDSUB_OVF_EN only)
// Options     : `define ADDSUB_OVF_EN to build the rsp_ovf port and logic.
// Revision    : 1.0  initial release
// ============================================================================
module addsub_rr_scheduler
    import addsub_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_m,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_result,
    output logic                    rsp_cout,
    output logic [$clog2(NREQ)-1:0] rsp_id
`ifdef ADDSUB_OVF_EN
    ,
    output logic                    rsp_ovf
`endif
);

    localparam int IW = $clog2(NREQ);

    state_t           r_state;
    logic [IW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_m;
    logic [IW-1:0]    r_id;

    logic [NREQ-1:0]  w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_hs;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_sel_m;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    // Grants are offered only in IDLE and never while reset is asserted.
    assign req_ready = ((r_state == IDLE) && rst_n) ? w_grant : '0;
    assign w_hs      = (r_state == IDLE) && (|(req_valid & req_ready));

    assign w_sel_a = req_a[w_idx*WIDTH +: WIDTH];
    assign w_sel_b = req_b[w_idx*WIDTH +: WIDTH];
    assign w_sel_m = req_m[w_idx];

    universal_adder_subtractor #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .A      (r_a),
        .B      (r_b),
        .M      (r_m),
        .Result (w_res),
        .Cout   (w_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_m        <= OP_ADD;
            r_id       <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_id     <= '0;
`ifdef ADDSUB_OVF_EN
            rsp_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_m     <= w_sel_m;
                        r_id    <= w_idx;
                        // Pointer moves past the winner only on a grant.
                        r_ptr   <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= w_res;
                    rsp_cout   <= w_cout;
                    rsp_id     <= r_id;
`ifdef ADDSUB_OVF_EN
                    rsp_ovf    <= signed_ovf(r_a[WIDTH-1], r_b[WIDTH-1],
                                             w_res[WIDTH-1], r_m);
`endif
                    rsp_valid  <= 1'b1;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : addsub_rr_scheduler
`default_nettype wire

// File: tb/tb_addsub_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_rr_scheduler
// Description : Self-checking bench for addsub_rr_scheduler (NREQ=2, WIDTH=4).
//               A cycle model tracks the expected grant and phase; expected
//               responses are queued at grant and compared while presented.
// Revision    : 1.0  initial release
// ============================================================================
module tb_addsub_rr_scheduler;

    localparam int NREQ  = 2;
    localparam int WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_m;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_cout;
    logic                  rsp_id;
`ifdef ADDSUB_OVF_EN
    logic                  rsp_ovf;
`endif

    addsub_rr_scheduler #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_m      (req_m),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id)
`ifdef ADDSUB_OVF_EN
        ,
        .rsp_ovf    (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] res;
        logic       cout;
        logic       id;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_phase = 0;     // 0 idle, 1 exec, 2 resp
    int   m_ptr = 0;
    int   grants[NREQ];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result for requester id from the operands currently driven.
    function automatic exp_t model(input int id);
        exp_t       e;
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        logic [4:0] s;
        int         sa;
        int         sbv;
        int         r;
        a   = req_a[id*WIDTH +: WIDTH];
        b   = req_b[id*WIDTH +: WIDTH];
        m   = req_m[id];
        s   = {1'b0, a} + {1'b0, (m ? ~b : b)} + {4'b0, m};
        sa  = $signed(a);
        sbv = $signed(b);
        r   = m ? (sa - sbv) : (sa + sbv);
        e.res  = s[3:0];
        e.cout = s[4];
        e.id   = id[0];
        e.ovf  = (r > 7) || (r < -8);
        return e;
    endfunction

    // Cycle monitor, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        int         pick;
        int         p;
        logic [1:0] expg;
        exp_t       e;
        if (!rst_n) begin
            check("ready_in_reset", req_ready, 0);
            m_phase = 0;
            m_ptr   = 0;
            sb.delete();
        end else begin
            case (m_phase)
                0: begin
                    pick = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        p = (m_ptr + k) % NREQ;
                        if (pick < 0 && req_valid[p]) pick = p;
                    end
                    expg = (pick < 0) ? 2'b00 : 2'(1 << pick);
                    check("grant", req_ready, expg);
                    check("idle_rsp_valid", rsp_valid, 0);
                    if (pick >= 0) begin
                        sb.push_back(model(pick));
                        grants[pick]++;
                        m_ptr   = (pick + 1) % NREQ;
                        m_phase = 1;
                    end
                end
                1: begin
                    check("exec_ready", req_ready, 0);
                    check("exec_rsp_valid", rsp_valid, 0);
                    m_phase = 2;
                end
                default: begin
                    check("resp_ready", req_ready, 0);
                    check("rsp_valid", rsp_valid, 1);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL rsp_unexpected observed=%0h expected=none", rsp_result);
                    end else begin
                        e = sb[0];
                        check("rsp_result", rsp_result, e.res);
                        check("rsp_cout", rsp_cout, e.cout);
                        check("rsp_id", rsp_id, e.id);
`ifdef ADDSUB_OVF_EN
                        check("rsp_ovf", rsp_ovf, e.ovf);
`endif
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            m_phase = 0;
                        end
                    end
                end
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for requester id to be granted; returns just after the
    // handshake edge.
    task automatic wait_grant(input int id);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL grant_timeout observed=none expected=grant%0d", id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [3:0] a, input logic [3:0] b, input logic m);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_m[id]                = m;
    endtask

    task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b, input logic m);
        set_op(id, a, b, m);
        req_valid[id] = 1'b1;
        wait_grant(id);
        req_valid[id] = 1'b0;
    endtask

    initial begin
        int g0;
        int g1;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_m     = '0;
        rsp_ready = 1'b1;
        grants[0] = 0;
        grants[1] = 0;

        // Reset state
        tick(3);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_rsp_cout", rsp_cout, 0);
        check("reset_rsp_id", rsp_id, 0);
        rst_n = 1'b1;
        tick(2);

        // Basic add / subtract, borrow and signed overflow cases
        do_op(0, 4'd5, 4'd3, 1'b0);  tick(3);
        do_op(1, 4'd12, 4'd2, 1'b0); tick(3);
        do_op(1, 4'd8, 4'd3, 1'b1);  tick(3);
        do_op(0, 4'd4, 4'd5, 1'b1);  tick(3);
        do_op(0, 4'd7, 4'd1, 1'b0);  tick(3);
        do_op(1, 4'd15, 4'd1, 1'b0); tick(3);

        // Both requesters continuously valid: 8 back-to-back operations
        g0 = grants[0];
        g1 = grants[1];
        set_op(0, 4'd3, 4'd9, 1'b0);
        set_op(1, 4'd2, 4'd6, 1'b1);
        req_valid = 2'b11;
        tick(24);
        req_valid = 2'b00;
        tick(3);
        check("rr_count0", grants[0] - g0, 4);
        check("rr_count1", grants[1] - g1, 4);

        // Response back-pressure with a competing request pending
        rsp_ready = 1'b0;
        do_op(0, 4'd9, 4'd4, 1'b0);
        set_op(1, 4'd6, 4'd6, 1'b1);
        req_valid[1] = 1'b1;
        tick(1);
        tick(5);
        rsp_ready = 1'b1;
        wait_grant(1);
        req_valid[1] = 1'b0;
        tick(3);

        // Reset during EXEC aborts the operation and clears the pointer
        do_op(0, 4'd1, 4'd1, 1'b0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("abort_rsp_valid", rsp_valid, 0);
        set_op(0, 4'd2, 4'd3, 1'b0);
        set_op(1, 4'd10, 4'd4, 1'b1);
        req_valid = 2'b11;
        wait_grant(0);
        req_valid = 2'b00;
        tick(4);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_addsub_rr_scheduler
`default_nettype wire
